// File: rtl/mmul_prec_seq.sv
// Precision-scalable MAC sequencer: splits 4/8-bit operands into chunks, issues one
// signed/unsigned chunk product per cycle and shift-accumulates into a wrapping accumulator.
module mmul_prec_seq #(
    parameter int unsigned CHUNK_W = 4,
    parameter int unsigned N_CHUNK = 2,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned PREC_W  = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
    localparam int unsigned OP_W   = CHUNK_W * N_CHUNK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [PREC_W-1:0] prec_a,
    input  logic [PREC_W-1:0] prec_b,
    input  logic              sgn_a,
    input  logic              sgn_b,
    input  logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);

    localparam int unsigned PW = 2 * CHUNK_W + 2;
    localparam logic [PREC_W-1:0] PrecMax = PREC_W'(N_CHUNK - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [PREC_W-1:0]   prec_a_q, prec_a_d, prec_b_q, prec_b_d;
    logic                sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
    logic [PREC_W-1:0]   i_q, i_d, j_q, j_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic [CHUNK_W-1:0]  a_chunk, b_chunk;
    logic [1:0]          mode;
    logic signed [CHUNK_W:0] a_s, b_s;
    logic signed [PW-1:0]    partial;
    logic [ACC_W-1:0]    partial_ext, partial_sh;
    int unsigned         shamt;
    logic                last_i, last_j;

    // Chunk multiplier datapath: each chunk is extended by one bit, signed only when its mode bit is set.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < N_CHUNK; k++) begin
            if (i_q == k[PREC_W-1:0]) a_chunk = op_a_q[k*CHUNK_W +: CHUNK_W];
            if (j_q == k[PREC_W-1:0]) b_chunk = op_b_q[k*CHUNK_W +: CHUNK_W];
        end
        last_i      = (i_q == prec_a_q);
        last_j      = (j_q == prec_b_q);
        mode[0]     = sgn_a_q & last_i;
        mode[1]     = sgn_b_q & last_j;
        a_s         = signed'({mode[0] & a_chunk[CHUNK_W-1], a_chunk});
        b_s         = signed'({mode[1] & b_chunk[CHUNK_W-1], b_chunk});
        partial     = PW'(a_s) * PW'(b_s);
        partial_ext = {{(ACC_W - PW){partial[PW-1]}}, partial};
        shamt       = CHUNK_W * (32'(i_q) + 32'(j_q));
        partial_sh  = partial_ext << shamt;
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        prec_a_d = prec_a_q;
        prec_b_d = prec_b_q;
        sgn_a_d  = sgn_a_q;
        sgn_b_d  = sgn_b_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_a_d   = op_a;
                    op_b_d   = op_b;
                    prec_a_d = (prec_a > PrecMax) ? PrecMax : prec_a;
                    prec_b_d = (prec_b > PrecMax) ? PrecMax : prec_b;
                    sgn_a_d  = sgn_a;
                    sgn_b_d  = sgn_b;
                    i_d      = '0;
                    j_d      = '0;
                    if (!acc_en) acc_d = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                acc_d = acc_q + partial_sh;
                if (last_j) begin
                    j_d = '0;
                    if (last_i) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            prec_a_q <= '0;
            prec_b_q <= '0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            prec_a_q <= prec_a_d;
            prec_b_q <= prec_b_d;
            sgn_a_q  <= sgn_a_d;
            sgn_b_q  <= sgn_b_d;
            i_q      <= i_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = acc_q;

endmodule
